// File: rtl/led_walk_ctrl_pkg.sv
// Shared encodings for the LED walk sequencer: pattern modes, FSM states and default bar width.
package led_walk_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ModeBounce = 2'd0,
    ModeRotate = 2'd1,
    ModeFill   = 2'd2,
    ModeRotAlt = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/led_step_timer.sv
// Step prescaler: latches the period on load, then strobes step_o once every div+1 enabled cycles.
module led_step_timer #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             step_o
);

  logic [DIV_W-1:0] reload_q, reload_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    reload_d = reload_q;
    cnt_d    = cnt_q;
    step_o   = 1'b0;
    if (load_i) begin
      reload_d = div_i;
      cnt_d    = div_i;
    end else if (en_i) begin
      if (cnt_q == '0) begin
        step_o = 1'b1;
        cnt_d  = reload_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reload_q <= '0;
      cnt_q    <= '0;
    end else begin
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/led_walk_ctrl.sv
// LED bar sequencer: walks a bounce/rotate/fill pattern at a programmed rate for a number of
// passes or until stopped; all outputs registered.
module led_walk_ctrl
  import led_walk_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned PASS_W = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  input  logic [DIV_W-1:0]  i_div,
  input  logic [PASS_W-1:0] i_passes,
  output logic [WIDTH-1:0]  o_led,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned PosW = $clog2(WIDTH);
  localparam logic [PosW-1:0] PosMax = PosW'(WIDTH - 1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [PosW-1:0]   pos_q, pos_d, pos_step;
  logic              dir_q, dir_d, dir_step;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [PASS_W-1:0] left_q, left_d;
  logic [WIDTH-1:0]  led_q, led_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load, step;

  assign load = (state_q == StIdle) && i_start;

  led_step_timer #(
    .DIV_W (DIV_W)
  ) u_step_timer (
    .clk_i  (i_clk),
    .rst_ni (i_reset_n),
    .load_i (load),
    .en_i   (state_q == StRun),
    .div_i  (i_div),
    .step_o (step)
  );

  // Position after one step; a step that lands on 0 marks the end of a pass.
  always_comb begin
    pos_step = pos_q + 1'b1;
    dir_step = dir_q;
    if (mode_q == ModeBounce) begin
      if (dir_q || (pos_q == PosMax)) begin
        pos_step = pos_q - 1'b1;
        dir_step = 1'b1;
      end
      if (pos_step == '0) dir_step = 1'b0;
    end else if (pos_q == PosMax) begin
      pos_step = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    passes_d = passes_q;
    left_d   = left_q;
    led_d    = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          mode_d   = mode_e'(i_mode);
          passes_d = i_passes;
          left_d   = i_passes;
          pos_d    = '0;
          dir_d    = 1'b0;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (i_stop) begin
          state_d = StDone;
        end else if (step) begin
          pos_d = pos_step;
          dir_d = dir_step;
          if ((pos_step == '0) && (passes_q != '0)) begin
            left_d = left_q - 1'b1;
            if (left_q == PASS_W'(1)) state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from next state so they line up with the registered state.
    if (state_d == StRun) begin
      busy_d = 1'b1;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (mode_d == ModeFill) led_d[i] = (i <= int'(pos_d));
        else                    led_d[i] = (i == int'(pos_d));
      end
    end
    done_d = (state_d == StDone);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= StIdle;
      mode_q   <= ModeBounce;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      passes_q <= '0;
      left_q   <= '0;
      led_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      passes_q <= passes_d;
      left_q   <= left_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_led  = led_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_led_walk_ctrl.sv
// Self-checking bench for led_walk_ctrl: cycle model from step arithmetic plus directed literals.
module tb_led_walk_ctrl;

  localparam int W  = 8;
  localparam int DW = 16;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop;
  logic [1:0]    mode;
  logic [DW-1:0] div;
  logic [PW-1:0] passes;
  logic [W-1:0]  led;
  logic          busy, done;

  always #5 clk = ~clk;

  led_walk_ctrl #(
    .WIDTH  (W),
    .DIV_W  (DW),
    .PASS_W (PW)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_start   (start),
    .i_stop    (stop),
    .i_mode    (mode),
    .i_div     (div),
    .i_passes  (passes),
    .o_led     (led),
    .o_busy    (busy),
    .o_done    (done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int bounce_exp[14] = '{'h01, 'h02, 'h04, 'h08, 'h10, 'h20, 'h40, 'h80,
                         'h40, 'h20, 'h10, 'h08, 'h04, 'h02};
  int fill_exp[8]    = '{'h01, 'h03, 'h07, 'h0f, 'h1f, 'h3f, 'h7f, 'hff};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: the k-th step of a run shows pattern index k mod pass length.
  function automatic int pass_len(input int md);
    return (md == 0) ? 2 * W - 2 : W;
  endfunction

  function automatic int exp_led(input int md, input int k);
    int s;
    int p;
    s = k % pass_len(md);
    p = (md == 0 && s >= W) ? 2 * W - 2 - s : s;
    return (md == 2) ? (1 << (p + 1)) - 1 : (1 << p);
  endfunction

  bit m_run, m_done;
  int m_n, m_mode, m_div, m_pass;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_n    <= 0;
    end else if (m_run) begin
      if (stop) begin
        m_run  <= 1'b0;
        m_done <= 1'b1;
      end else begin
        m_n <= m_n + 1;
        if (m_pass != 0 && (m_n + 1) / (m_div + 1) >= m_pass * pass_len(m_mode)) begin
          m_run  <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (start) begin
      m_run  <= 1'b1;
      m_n    <= 0;
      m_mode <= int'(mode);
      m_div  <= int'(div);
      m_pass <= int'(passes);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_led", int'(led), m_run ? exp_led(m_mode, m_n / (m_div + 1)) : 0);
      chk("model_busy", int'(busy), int'(m_run));
      chk("model_done", int'(done), int'(m_done));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic kick(input int md, input int dv, input int ps);
    mode   = 2'(md);
    div    = DW'(dv);
    passes = PW'(ps);
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    mode   = '0;
    div    = '0;
    passes = '0;
    #1;
    chk("reset_led", int'(led), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // BOUNCE, div=0, one pass
    kick(0, 0, 1);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("bounce_led", int'(led), bounce_exp[i]);
    end
    @(negedge clk);
    chk("bounce_done", int'(done), 1);
    chk("bounce_done_led", int'(led), 0);
    chk("bounce_done_busy", int'(busy), 0);
    @(negedge clk);
    chk("bounce_idle_done", int'(done), 0);
    chk("bounce_idle_busy", int'(busy), 0);
    tick(1);

    // ROTATE, div=1, two passes
    kick(1, 1, 2);
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (i == 1 || i == 2) chk("rot_led_first", int'(led), 'h01);
      if (i == 3)  chk("rot_led_step", int'(led), 'h02);
      if (i == 32) chk("rot_busy_last", int'(busy), 1);
      if (i == 32) chk("rot_led_last", int'(led), 'h80);
      if (i == 33) chk("rot_done", int'(done), 1);
    end
    tick(2);

    // FILL, div=0, one pass
    kick(2, 0, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("fill_led", int'(led), fill_exp[i]);
    end
    @(negedge clk);
    chk("fill_done", int'(done), 1);
    chk("fill_done_led", int'(led), 0);
    tick(2);

    // ROTATE forever, then stop coincident with a step
    kick(1, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 8) chk("inf_led_top", int'(led), 'h80);
      if (i == 9) chk("inf_led_wrap", int'(led), 'h01);
      if (i == 9) chk("inf_no_done", int'(done), 0);
    end
    tick(1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    @(negedge clk);
    chk("stop_done", int'(done), 1);
    chk("stop_led", int'(led), 0);
    @(negedge clk);
    chk("stop_idle_done", int'(done), 0);
    chk("stop_idle_busy", int'(busy), 0);
    tick(1);

    // start held through RUN must not restart
    kick(1, 0, 1);
    start = 1'b1;
    tick(4);
    start = 1'b0;
    @(negedge clk);
    chk("held_start_led", int'(led), 'h10);
    tick(6);

    // start and stop together in IDLE: start wins
    stop = 1'b1;
    kick(1, 0, 1);
    stop = 1'b0;
    @(negedge clk);
    chk("start_stop_busy", int'(busy), 1);
    chk("start_stop_led", int'(led), 'h01);
    tick(10);

    // div changed mid-run keeps the latched rate
    kick(1, 2, 1);
    div = '0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 3) chk("div_hold_led", int'(led), 'h01);
      if (i == 4) chk("div_step_led", int'(led), 'h02);
    end
    tick(24);

    // mode 3 behaves as ROTATE (model-checked)
    kick(3, 0, 1);
    tick(12);

    // reset mid-run: async clear, no done pulse
    kick(1, 3, 0);
    tick(9);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_led", int'(led), 0);
    chk("rst_async_busy", int'(busy), 0);
    chk("rst_async_done", int'(done), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_done", int'(done), 0);
    end
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_done", int'(done), 0);
    chk("rst_rel_busy", int'(busy), 0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_walk_ctrl.md
# led_walk_ctrl

Sequencer for the LED bar. On a start request it latches a pattern mode, step period and pass count, then walks the LEDs at the programmed rate until the passes are exhausted or a stop is requested. It signals busy and done to the host-side logic, and sits between board-level control and the LED pins, replacing the free-running walker. Outputs are fully registered.

## Interface
- WIDTH, 8: LED count; must be ≥ 2.
- DIV_W, 16: step-divider width.
- PASS_W, 4: pass-count width.
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset_n  in  1  reset, asynchronous and active-low.
- i_start  in  1  start request, sampled in IDLE only.
- i_stop  in  1  abort request, sampled in RUN only.
- i_mode  in  2  pattern: 0 BOUNCE, 1 ROTATE, 2 FILL, 3 treated as ROTATE.
- i_div  in  DIV_W  step period minus one, in cycles.
- i_passes  in  PASS_W  passes to run; 0 runs until stop.
- o_led  out  WIDTH  LED drive.
- o_busy  out  1  high while in RUN.
- o_done  out  1  one-cycle pulse on completion or abort.

## Operation
- Reset (asynchronous assert, synchronous release): state IDLE, o_led=0, o_busy=0, o_done=0, all counters 0.
- States: IDLE, RUN, DONE.
- IDLE
  - o_led=0.
  - i_start=1 latches mode, div and passes, sets pos=0 and loads the prescaler with div.
  - Then → RUN.
- RUN
  - o_busy=1.
  - Prescaler decrements each cycle. At 0 it reloads div and issues a step, so a step occurs every div+1 cycles (div=0 steps every cycle).
- Patterns, all driven from pos:
  - BOUNCE: pos goes 0→W-1→1, then back to 0. Pass length 2W-2 steps. o_led = one-hot at pos.
  - ROTATE: pos goes 0→W-1, then wraps to 0. Pass length W steps. o_led = one-hot at pos.
  - FILL: pos goes 0→W-1, then wraps to 0. Pass length W steps. o_led = (2^(pos+1))-1 (thermometer).
- Pass completion: a step from the last position of a pass back to pos 0.
  - If latched passes ≠ 0, decrement passes_left.
  - When passes_left reaches 0 → DONE, and pos 0 is not displayed again.
  - If latched passes = 0, wrap indefinitely.
- i_stop=1 in RUN → DONE on the next edge. Stop takes priority over a coincident step.
- DONE
  - Lasts exactly one cycle: o_done=1, o_busy=0, o_led=0.
  - Then → IDLE.
  - i_start during DONE is ignored.
- i_start while in RUN or DONE is ignored.
- i_stop while in IDLE is ignored. i_start and i_stop together in IDLE: start is taken.
- Input changes on i_mode, i_div or i_passes after latching have no effect until the next start.
- Reset asserted mid-run returns immediately to the reset values. There is no o_done pulse.

## Timing
- i_start sampled at edge t:
  - o_busy=1 and o_led shows the pos-0 pattern from t+1.
  - First step is visible at t+1+(div+1).
- Run length with passes=P (P≠0):
  - RUN lasts P·L·(div+1) cycles, where L is the pass length.
  - o_done is high for the single following cycle.
  - The next start is accepted one cycle after o_done.
- i_stop sampled at edge s: DONE is visible at s+1 (o_done=1, o_led=0), IDLE at s+2.
- Arithmetic:
  - pos is clog2(WIDTH) bits.
  - BOUNCE direction is held in a 1-bit register: it flips at pos=W-1 and clears on wrap to 0.
  - Prescaler and pass counters are unsigned with no overflow paths.

## Structure
- Mode encodings (BOUNCE/ROTATE/FILL) and the state encoding live in the team's shared parameters header, alongside DEFAULT_WIDTH.
- WIDTH defaults to DEFAULT_WIDTH.
- Sub-module led_step_timer (DIV_W): prescaler with load/enable, outputs a one-cycle step strobe. The controller holds the FSM, pos/direction, pass counter and the pattern decode.

## Test plan
- Reset mid-run (ROTATE, div=3): assert i_reset_n low → o_led=0, o_busy=0 asynchronously, and no o_done pulse.
- BOUNCE, W=8, div=0, passes=1, start at t:
  - o_led = 01,02,04,08,10,20,40,80,40,20,10,08,04,02 on t+1…t+14.
  - t+15: o_done=1, o_led=00, o_busy=0.
  - t+16: IDLE.
- ROTATE, div=1, passes=2:
  - Each pattern held 2 cycles; 01…80 sequence repeated twice.
  - o_busy high for 32 cycles; o_done at t+33.
- FILL, div=0, passes=1: o_led = 01,03,07,0F,1F,3F,7F,FF, then o_done with o_led=00.
- passes=0, ROTATE, div=0:
  - Wraps 80→01 with no done.
  - i_stop coincident with a step at edge s → o_done=1, o_led=0 at s+1; the stepped pattern is never shown.
- Ignored and simultaneous inputs:
  - i_start held continuously during RUN → no restart.
  - i_start and i_stop together in IDLE → run starts.
  - Changing i_div mid-run → step rate unchanged.
